// File: rtl/dcmac_link_sequencer.sv
// dcmac_link_sequencer
//   Brings up the GT/DCMAC pair for two 100GbE ports and recovers them on failure.
//   A global FSM pulses the GT reset-all, waits for both TX resets to finish, then
//   lets two independent port FSMs chase RX alignment. Each port retries its RX
//   datapath reset until alignment is reached or its retry budget runs out.
//
// Ports (all in the s_axi_clk domain):
//   s_axi_clk, s_axi_resetn      clock, asynchronous active-low reset
//   start                        one-cycle pulse, (re)starts the whole sequence
//   gt_tx_reset_done[1:0]        per-port TX reset done (already synchronised)
//   gt_rx_reset_done[1:0]        per-port RX reset done (already synchronised)
//   rx_aligned[1:0]              per-port PCS alignment (already synchronised)
//   user_gt_reset_all            GT reset-all request
//   user_gt_reset_rx_datapath    per-port RX datapath reset
//   link_up, port_fail           per-port status
//   tx_fail                      TX reset-done timeout
//   busy                         bring-up or recovery in progress
//   retry_count[7:0]             [3:0] port0, [7:4] port1, consecutive RX resets
//
// All outputs are registered from the current FSM state, so every output follows
// the state that produces it by one cycle.
module dcmac_link_sequencer #(
    parameter int unsigned RESET_CYCLES   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ALIGN_CYCLES   = 500000,
    parameter int unsigned LOSS_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       s_axi_clk,
    input  logic       s_axi_resetn,
    input  logic       start,
    input  logic [1:0] gt_tx_reset_done,
    input  logic [1:0] gt_rx_reset_done,
    input  logic [1:0] rx_aligned,
    output logic       user_gt_reset_all,
    output logic [1:0] user_gt_reset_rx_datapath,
    output logic [1:0] link_up,
    output logic [1:0] port_fail,
    output logic       tx_fail,
    output logic       busy,
    output logic [7:0] retry_count
);

    // One counter width covers every timed interval (pulse, waits, loss filter).
    localparam int unsigned WAIT_MAX = (TIMEOUT_CYCLES > ALIGN_CYCLES) ? TIMEOUT_CYCLES
                                                                      : ALIGN_CYCLES;
    localparam int unsigned PULSE_MAX = (RESET_CYCLES > LOSS_CYCLES) ? RESET_CYCLES
                                                                     : LOSS_CYCLES;
    localparam int unsigned CNT_MAX = (WAIT_MAX > PULSE_MAX) ? WAIT_MAX : PULSE_MAX;
    localparam int unsigned TW = $clog2(CNT_MAX);

    typedef logic [TW-1:0] cnt_t;

    localparam cnt_t       RESET_LAST   = cnt_t'(RESET_CYCLES - 1);
    localparam cnt_t       TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
    localparam cnt_t       ALIGN_LAST   = cnt_t'(ALIGN_CYCLES - 1);
    localparam cnt_t       LOSS_LAST    = cnt_t'(LOSS_CYCLES - 1);
    localparam logic [3:0] MAX_RETRY    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {GIdle, GReset, GWaitTx, GPorts, GFail} g_state_t;
    typedef enum logic [2:0] {PIdle, PWaitAlign, PRst, PWaitDone, PUp, PFail} p_state_t;

    g_state_t   g_state_q, g_state_d;
    cnt_t       g_cnt_q, g_cnt_d;
    p_state_t   p_state_q [2];
    p_state_t   p_state_d [2];
    cnt_t       p_cnt_q [2];
    cnt_t       p_cnt_d [2];
    logic [3:0] retry_q [2];
    logic [3:0] retry_d [2];

    logic tx_ok;
    logic ports_run;
    logic busy_d;

    assign tx_ok = &gt_tx_reset_done;
    // Ports only advance while the global FSM stays in GPorts this cycle.
    assign ports_run = (g_state_q == GPorts) && tx_ok && !start;
    assign retry_count = {retry_q[1], retry_q[0]};

    // Global sequencer; start overrides everything.
    always_comb begin
        g_state_d = g_state_q;
        g_cnt_d   = g_cnt_q;
        if (start) begin
            g_state_d = GReset;
            g_cnt_d   = '0;
        end else begin
            unique case (g_state_q)
                GReset: begin
                    if (g_cnt_q == RESET_LAST) begin
                        g_state_d = GWaitTx;
                        g_cnt_d   = '0;
                    end else begin
                        g_cnt_d = g_cnt_q + 1'b1;
                    end
                end
                GWaitTx: begin
                    if (tx_ok) begin
                        g_state_d = GPorts;
                        g_cnt_d   = '0;
                    end else if (g_cnt_q == TIMEOUT_LAST) begin
                        g_state_d = GFail;
                    end else begin
                        g_cnt_d = g_cnt_q + 1'b1;
                    end
                end
                GPorts: begin
                    // TX loss restarts the GT without charging a port retry.
                    if (!tx_ok) begin
                        g_state_d = GReset;
                        g_cnt_d   = '0;
                    end
                end
                default: g_state_d = g_state_q;
            endcase
        end
    end

    // Per-port sequencers.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic req_rst;
            req_rst      = 1'b0;
            p_state_d[p] = p_state_q[p];
            p_cnt_d[p]   = p_cnt_q[p];
            retry_d[p]   = retry_q[p];
            if (!ports_run) begin
                p_state_d[p] = PIdle;
                p_cnt_d[p]   = '0;
                retry_d[p]   = '0;
            end else begin
                unique case (p_state_q[p])
                    PIdle: begin
                        p_state_d[p] = PWaitAlign;
                        p_cnt_d[p]   = '0;
                    end
                    PWaitAlign: begin
                        // Success is checked first so it beats a same-cycle expiry.
                        if (gt_rx_reset_done[p] && rx_aligned[p]) begin
                            p_state_d[p] = PUp;
                            p_cnt_d[p]   = '0;
                            retry_d[p]   = '0;
                        end else if (p_cnt_q[p] == ALIGN_LAST) begin
                            req_rst = 1'b1;
                        end else begin
                            p_cnt_d[p] = p_cnt_q[p] + 1'b1;
                        end
                    end
                    PRst: begin
                        if (p_cnt_q[p] == RESET_LAST) begin
                            p_state_d[p] = PWaitDone;
                            p_cnt_d[p]   = '0;
                        end else begin
                            p_cnt_d[p] = p_cnt_q[p] + 1'b1;
                        end
                    end
                    PWaitDone: begin
                        if (gt_rx_reset_done[p]) begin
                            p_state_d[p] = PWaitAlign;
                            p_cnt_d[p]   = '0;
                        end else if (p_cnt_q[p] == TIMEOUT_LAST) begin
                            req_rst = 1'b1;
                        end else begin
                            p_cnt_d[p] = p_cnt_q[p] + 1'b1;
                        end
                    end
                    PUp: begin
                        // Counter doubles as the consecutive-low loss filter.
                        if (rx_aligned[p]) begin
                            p_cnt_d[p] = '0;
                        end else if (p_cnt_q[p] == LOSS_LAST) begin
                            req_rst = 1'b1;
                        end else begin
                            p_cnt_d[p] = p_cnt_q[p] + 1'b1;
                        end
                    end
                    default: p_state_d[p] = p_state_q[p];
                endcase

                if (req_rst) begin
                    if (retry_q[p] == MAX_RETRY) begin
                        p_state_d[p] = PFail;
                    end else begin
                        p_state_d[p] = PRst;
                        p_cnt_d[p]   = '0;
                        retry_d[p]   = (retry_q[p] == 4'hF) ? 4'hF : retry_q[p] + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy_d = (g_state_q == GReset) || (g_state_q == GWaitTx);
        for (int p = 0; p < 2; p++) begin
            if ((g_state_q == GPorts) && (p_state_q[p] != PUp) && (p_state_q[p] != PFail)) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            g_state_q                 <= GIdle;
            g_cnt_q                   <= '0;
            user_gt_reset_all         <= 1'b0;
            tx_fail                   <= 1'b0;
            busy                      <= 1'b0;
            user_gt_reset_rx_datapath <= '0;
            link_up                   <= '0;
            port_fail                 <= '0;
            for (int p = 0; p < 2; p++) begin
                p_state_q[p] <= PIdle;
                p_cnt_q[p]   <= '0;
                retry_q[p]   <= '0;
            end
        end else begin
            g_state_q         <= g_state_d;
            g_cnt_q           <= g_cnt_d;
            user_gt_reset_all <= (g_state_q == GReset);
            tx_fail           <= (g_state_q == GFail);
            busy              <= busy_d;
            for (int p = 0; p < 2; p++) begin
                p_state_q[p]                 <= p_state_d[p];
                p_cnt_q[p]                   <= p_cnt_d[p];
                retry_q[p]                   <= retry_d[p];
                user_gt_reset_rx_datapath[p] <= (p_state_q[p] == PRst);
                link_up[p]                   <= (p_state_q[p] == PUp);
                port_fail[p]                 <= (p_state_q[p] == PFail);
            end
        end
    end

endmodule

// File: tb/tb_dcmac_link_sequencer.sv
// Bench for dcmac_link_sequencer: directed scenarios plus a randomised phase, all
// checked every cycle against a deadline-based behavioural model, with a few
// hand-computed literal checks on top.
module tb_dcmac_link_sequencer;

    localparam int RST_C  = 32;
    localparam int TMO_C  = 100;
    localparam int ALN_C  = 80;
    localparam int LOSS_C = 16;
    localparam int MAXR   = 7;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [1:0] tx_done = 2'b11;
    logic [1:0] rx_done = 2'b11;
    logic [1:0] aligned = 2'b11;

    logic       reset_all;
    logic [1:0] rx_dp;
    logic [1:0] link_up;
    logic [1:0] port_fail;
    logic       tx_fail;
    logic       busy;
    logic [7:0] retry_count;
    logic [16:0] got_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign got_vec = {reset_all, rx_dp, link_up, port_fail, tx_fail, busy, retry_count};

    dcmac_link_sequencer #(
        .RESET_CYCLES  (RST_C),
        .TIMEOUT_CYCLES(TMO_C),
        .ALIGN_CYCLES  (ALN_C),
        .LOSS_CYCLES   (LOSS_C),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .s_axi_clk                (clk),
        .s_axi_resetn             (rst_n),
        .start                    (start),
        .gt_tx_reset_done         (tx_done),
        .gt_rx_reset_done         (rx_done),
        .rx_aligned               (aligned),
        .user_gt_reset_all        (reset_all),
        .user_gt_reset_rx_datapath(rx_dp),
        .link_up                  (link_up),
        .port_fail                (port_fail),
        .tx_fail                  (tx_fail),
        .busy                     (busy),
        .retry_count              (retry_count)
    );

    // ---------------- behavioural model ----------------
    // Each timed phase remembers the absolute edge index at which it expires.
    typedef enum int {MIdle, MReset, MWaitTx, MPorts, MFail} gphase_t;
    typedef enum int {QIdle, QAlign, QPulse, QDone, QUp, QFail} pphase_t;

    int          cyc = 0;
    gphase_t     gph = MIdle;
    int          g_until = 0;
    pphase_t     pph [2];
    int          p_until [2];
    int          retries [2];
    int          lows [2];
    logic [16:0] exp_out = '0;

    task automatic ports_clear();
        for (int p = 0; p < 2; p++) begin
            pph[p]     = QIdle;
            retries[p] = 0;
            lows[p]    = 0;
        end
    endtask

    task automatic retry_or_fail(input int p);
        if (retries[p] == MAXR) begin
            pph[p] = QFail;
        end else begin
            retries[p] = (retries[p] < 15) ? retries[p] + 1 : 15;
            pph[p]     = QPulse;
            p_until[p] = cyc + RST_C;
        end
    endtask

    task automatic port_step(input int p);
        case (pph[p])
            QIdle: begin
                pph[p]     = QAlign;
                p_until[p] = cyc + ALN_C;
            end
            QAlign: begin
                if (rx_done[p] && aligned[p]) begin
                    pph[p]     = QUp;
                    retries[p] = 0;
                    lows[p]    = 0;
                end else if (cyc == p_until[p]) begin
                    retry_or_fail(p);
                end
            end
            QPulse: begin
                if (cyc == p_until[p]) begin
                    pph[p]     = QDone;
                    p_until[p] = cyc + TMO_C;
                end
            end
            QDone: begin
                if (rx_done[p]) begin
                    pph[p]     = QAlign;
                    p_until[p] = cyc + ALN_C;
                end else if (cyc == p_until[p]) begin
                    retry_or_fail(p);
                end
            end
            QUp: begin
                if (aligned[p]) begin
                    lows[p] = 0;
                end else begin
                    lows[p]++;
                    if (lows[p] == LOSS_C) retry_or_fail(p);
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        logic       e_all, e_txf, e_busy;
        logic [1:0] e_dp, e_up, e_pf;
        cyc++;
        // Outputs reflect the phase held before this edge.
        e_all  = (gph == MReset);
        e_txf  = (gph == MFail);
        for (int p = 0; p < 2; p++) begin
            e_dp[p] = (pph[p] == QPulse);
            e_up[p] = (pph[p] == QUp);
            e_pf[p] = (pph[p] == QFail);
        end
        e_busy = (gph == MReset) || (gph == MWaitTx) ||
                 ((gph == MPorts) && ((e_up | e_pf) != 2'b11));
        if (start) begin
            gph     = MReset;
            g_until = cyc + RST_C;
            ports_clear();
        end else begin
            case (gph)
                MReset: begin
                    if (cyc == g_until) begin
                        gph     = MWaitTx;
                        g_until = cyc + TMO_C;
                    end
                end
                MWaitTx: begin
                    if (tx_done == 2'b11) gph = MPorts;
                    else if (cyc == g_until) gph = MFail;
                end
                MPorts: begin
                    if (tx_done != 2'b11) begin
                        gph     = MReset;
                        g_until = cyc + RST_C;
                        ports_clear();
                    end else begin
                        for (int p = 0; p < 2; p++) port_step(p);
                    end
                end
                default: ;
            endcase
        end
        exp_out = {e_all, e_dp, e_up, e_pf, e_txf, e_busy,
                   retries[1][3:0], retries[0][3:0]};
    endtask

    initial begin
        ports_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                gph     = MIdle;
                ports_clear();
                exp_out = '0;
            end else begin
                model_step();
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (got_vec !== exp_out) begin
                n_bad++;
                $display("FAIL outputs t=%0t got=%05h want=%05h", $time, got_vec, exp_out);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int         pulses [2];
    logic [1:0] dp_prev = 2'b00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (rx_dp[p] && !dp_prev[p]) pulses[p]++;
            end
            dp_prev = rx_dp;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_link(input logic [1:0] want, input int budget, input string name);
        int k;
        k = 0;
        while (link_up !== want && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {30'd0, link_up}, {30'd0, want});
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int k;
        pulses[0] = 0;
        pulses[1] = 0;

        // Reset and normal bring-up.
        tick(3);
        rst_n = 1'b1;
        check("reset_state", {15'd0, got_vec}, 32'd0);
        tick(5);
        pulse_start();
        check("reset_all_delay", {31'd0, reset_all}, 32'd0);
        tick(1);
        check("reset_all_rise", {31'd0, reset_all}, 32'd1);
        k = 0;
        while (reset_all === 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        check("reset_all_len", k, 32);
        wait_link(2'b11, 300, "bringup_link");
        check("bringup_retry", {24'd0, retry_count}, 32'd0);
        check("bringup_busy", {31'd0, busy}, 32'd0);

        // Port1 misses two alignment windows.
        aligned   = 2'b01;
        pulses[0] = 0;
        pulses[1] = 0;
        pulse_start();
        k = 0;
        while (!(pulses[1] == 2 && rx_dp[1] == 1'b0) && k < 2000) begin
            tick(1);
            k++;
        end
        check("p1_pulses", pulses[1], 2);
        check("p1_retry_mid", {28'd0, retry_count[7:4]}, 32'd2);
        check("p0_undisturbed", {27'd0, retry_count[3:0], link_up[0]}, 32'd1);
        check("p0_no_pulse", pulses[0], 0);
        aligned = 2'b11;
        wait_link(2'b11, 300, "p1_relink");
        check("p1_retry_clear", {24'd0, retry_count}, 32'd0);

        // Loss-of-link filter.
        pulses[0] = 0;
        aligned[0] = 1'b0;
        tick(15);
        aligned[0] = 1'b1;
        tick(5);
        check("glitch15_link", {30'd0, link_up}, 32'd3);
        check("glitch15_pulse", pulses[0], 0);
        aligned[0] = 1'b0;
        tick(16);
        aligned[0] = 1'b1;
        tick(2);
        check("loss16_down", {30'd0, link_up}, 32'd2);
        wait_link(2'b11, 300, "loss_relink");
        check("loss_pulses", pulses[0], 1);

        // Port0 never aligns.
        aligned   = 2'b10;
        pulses[0] = 0;
        pulses[1] = 0;
        pulse_start();
        k = 0;
        while (port_fail[0] !== 1'b1 && k < 3000) begin
            tick(1);
            k++;
        end
        check("fail_port_fail", {30'd0, port_fail}, 32'd1);
        check("fail_pulses", pulses[0], 7);
        check("fail_link", {30'd0, link_up}, 32'd2);
        check("fail_retry", {28'd0, retry_count[3:0]}, 32'd7);
        check("fail_busy", {31'd0, busy}, 32'd0);

        // TX reset never completes.
        tx_done = 2'b00;
        aligned = 2'b11;
        pulse_start();
        k = 0;
        while (tx_fail !== 1'b1 && k < 500) begin
            tick(1);
            k++;
        end
        check("tx_fail_time", k, 133);
        check("tx_fail_busy", {31'd0, busy}, 32'd0);
        check("tx_fail_ports", {28'd0, port_fail, link_up}, 32'd0);
        tx_done = 2'b11;
        pulse_start();
        check("tx_fail_hold", {31'd0, tx_fail}, 32'd1);
        tick(1);
        check("tx_fail_clear", {30'd0, tx_fail, reset_all}, 32'd1);
        wait_link(2'b11, 400, "tx_recover_link");

        // Randomised traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(149) == 0);
            tx_done = ($urandom_range(149) == 0) ? 2'($urandom_range(3)) : 2'b11;
            for (int p = 0; p < 2; p++) begin
                rx_done[p] = ($urandom_range(5) != 0);
                if ($urandom_range(29) == 0) aligned[p] = ~aligned[p];
            end
            tick(1);
        end
        start   = 1'b0;
        tx_done = 2'b11;
        rx_done = 2'b11;

        // Async reset while an RX datapath reset is high.
        aligned = 2'b01;
        pulse_start();
        k = 0;
        while (rx_dp[1] !== 1'b1 && k < 1000) begin
            tick(1);
            k++;
        end
        check("rxdp_seen", {31'd0, rx_dp[1]}, 32'd1);
        tick(3);
        #2 rst_n = 1'b0;
        #1 check("async_clear", {15'd0, got_vec}, 32'd0);
        tick(2);
        rst_n   = 1'b1;
        aligned = 2'b11;
        tick(40);
        check("idle_after_reset", {15'd0, got_vec}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcmac_link_sequencer.md
Name: dcmac_link_sequencer

Overview:
- Sequences GT/DCMAC bring-up and recovery for the two 100GbE MAC ports, in the s_axi_clk domain.
- Drives user_gt_reset_all and user_gt_reset_rx_datapath[1:0] into the DCMAC clock/reset helper.
- Consumes the helper's s_axi_clk-synchronized gt_tx_reset_done and gt_rx_reset_done, plus a synchronized per-port rx_aligned status.
- Retries each port's RX datapath independently and reports per-port link state, retries and failure.

Parameters:
RESET_CYCLES, 32, cycles a reset output is held high per pulse (>=2)
TIMEOUT_CYCLES, 1000000, max wait for a reset_done (tx or rx)
ALIGN_CYCLES, 500000, max wait for rx_aligned after rx reset done
LOSS_CYCLES, 16, consecutive cycles of rx_aligned low in UP before recovery
MAX_RETRIES, 7, RX datapath resets allowed per port before port fail (<=15)

Ports:
s_axi_clk  in  1  clock
s_axi_resetn  in  1  reset; asynchronous, active-low
start  in  1  single-cycle pulse; (re)starts full sequence
gt_tx_reset_done  in  2  per-port TX reset done, already synchronous
gt_rx_reset_done  in  2  per-port RX reset done, already synchronous
rx_aligned  in  2  per-port PCS alignment status, already synchronous
user_gt_reset_all  out  1  GT reset-all request
user_gt_reset_rx_datapath  out  2  per-port RX datapath reset
link_up  out  2  per-port link established
port_fail  out  2  per-port retries exhausted
tx_fail  out  1  TX reset_done timeout
busy  out  1  sequence in progress
retry_count  out  8  [3:0] port0, [7:4] port1; consecutive RX resets, saturating at 15

Behaviour:
- Async reset: all outputs 0; global FSM G_IDLE; port FSMs P_IDLE; all counters 0. Outputs are registered.
- Global FSM:
  - G_IDLE -> start -> G_RESET.
  - G_RESET: user_gt_reset_all=1 for exactly RESET_CYCLES cycles. If start is sampled at edge N, user_gt_reset_all rises after edge N+1. Then G_WAIT_TX.
  - G_WAIT_TX: when both gt_tx_reset_done bits are 1 -> G_PORTS. If TIMEOUT_CYCLES elapse first -> G_FAIL (tx_fail=1).
  - G_PORTS: port FSMs run. Any gt_tx_reset_done bit low -> G_RESET. This path is not counted as a retry, and link_up and port state are cleared.
  - G_FAIL: holds until start.
  - start in any state (including G_FAIL) -> G_RESET. All flags and retry_count are cleared and port FSMs forced to P_IDLE. start wins over any same-cycle timeout or event.
- Port FSM (one per port, independent; active only in G_PORTS, else P_IDLE with outputs 0):
  - P_IDLE -> P_WAIT_ALIGN on G_PORTS entry; ALIGN timer loaded.
  - P_WAIT_ALIGN: gt_rx_reset_done&rx_aligned -> P_UP. Timer expires -> P_RST.
  - P_RST: if retry_count==MAX_RETRIES -> P_FAIL. Otherwise retry_count+1, user_gt_reset_rx_datapath[p]=1 for RESET_CYCLES cycles, then P_WAIT_DONE.
  - P_WAIT_DONE: gt_rx_reset_done[p]=1 -> P_WAIT_ALIGN. TIMEOUT_CYCLES elapse -> P_RST.
  - P_UP: link_up[p]=1 the cycle after entry; retry_count[p] cleared on entry. rx_aligned[p] low for LOSS_CYCLES consecutive cycles -> link_up=0, P_RST. A shorter low glitch resets the loss counter; no action.
  - P_FAIL: port_fail[p]=1, reset output low; exits only via start or G_RESET.
- A check of rx_aligned that coincides with the timer's last cycle succeeds: success beats timeout.
- busy=1 in G_RESET and G_WAIT_TX, and in G_PORTS while any port is not in P_UP/P_FAIL; else 0.
- Timers: one per port plus one global; counter width from max(TIMEOUT_CYCLES, ALIGN_CYCLES); no wrap (stops at expiry).
- Mid-operation async reset asserted while a reset output is high: that output drops immediately.

Test Plan:
- Normal bring-up: reset, start at cycle 10; all done/aligned high -> reset_all high cycles 11..42 (RESET_CYCLES=32), link_up=2'b11, retry_count=0, busy=0.
- Port1 alignment: port1 rx_aligned low for 2 ALIGN windows then high -> port1 rx_datapath pulsed twice (32 cycles each), port1 retry_count=2 until P_UP then 0, port0 undisturbed.
- Persistent fail: port0 rx_aligned stuck low (MAX_RETRIES=7) -> exactly 7 rx_datapath pulses, then port_fail=2'b01; port1 link_up stays 1.
- Loss of link: in P_UP, rx_aligned[0] low 15 cycles -> no action; low 16 cycles -> link_up[0]=0, one rx_datapath pulse, relink.
- TX timeout: gt_tx_reset_done held 0 -> tx_fail=1 after TIMEOUT_CYCLES, busy=0; start -> tx_fail=0, reset_all re-pulsed.
- Async reset mid-sequence: deassert s_axi_resetn during rx_datapath pulse -> all outputs 0 immediately; no activity until next start.
